// File: rtl/ex_wb_stage_pkg.sv
// ex_pkg: shared definitions for the execute/writeback stage.
//   - PSR bit positions inside the 5-bit {C,F,Z,L,N} status word
//   - FSM state encoding for the WAIT stall sequencer
//   - PSR reset value and default datapath widths
package ex_pkg;

  localparam int PSR_C = 4;
  localparam int PSR_F = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_L = 1;
  localparam int PSR_N = 0;

  localparam int PSR_W = 5;
  localparam logic [PSR_W-1:0] PSR_RESET = 5'b0;

  localparam int EX_WIDTH      = 16;
  localparam int EX_REG_ADDR_W = 4;
  localparam int EX_WAIT_CNT_W = 8;
  localparam int EX_RETIRE_W   = 16;

  typedef enum logic {
    RUN_ST  = 1'b0,
    WAIT_ST = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_wb_stage_if.sv
// ex_wb_if: bundles the ALU-side handshake, the register-file write port and
// the status outputs of the execute/writeback stage.
//   master modport: the upstream/ALU side (drives in_* and flush).
//   slave modport : the stage itself (drives in_ready, wb_*, psr, busy, counters).
interface ex_wb_if
  import ex_pkg::*;
#(
  parameter int WIDTH      = EX_WIDTH,
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int RETIRE_W   = EX_RETIRE_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_y;
  logic                  in_y_valid;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [PSR_W-1:0]      in_flags_raw;
  logic [PSR_W-1:0]      in_flags_sel;
  logic                  in_flags_en;
  logic                  in_wait;
  logic                  flush;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic [PSR_W-1:0]      psr;
  logic                  psr_c;
  logic                  busy;
  logic [RETIRE_W-1:0]   retire_count;

  modport master (
    output in_valid, in_y, in_y_valid, in_rd, in_flags_raw, in_flags_sel,
           in_flags_en, in_wait, flush,
    input  in_ready, wb_en, wb_addr, wb_data, psr, psr_c, busy, retire_count
  );

  modport slave (
    input  in_valid, in_y, in_y_valid, in_rd, in_flags_raw, in_flags_sel,
           in_flags_en, in_wait, flush,
    output in_ready, wb_en, wb_addr, wb_data, psr, psr_c, busy, retire_count
  );

endinterface

// File: rtl/ex_wb_stage_psr_reg.sv
// psr_reg: 5-bit processor status register with per-bit masked update.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (loads PSR_RESET)
//   en_i    : update enable (instruction accepted this cycle)
//   mask_i  : bits to replace; unmasked bits hold
//   raw_i   : new flag values {C,F,Z,L,N}
//   psr_o   : current status word
module psr_reg
  import ex_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [PSR_W-1:0] mask_i,
  input  logic [PSR_W-1:0] raw_i,
  output logic [PSR_W-1:0] psr_o
);

  logic [PSR_W-1:0] psr_q;
  logic [PSR_W-1:0] psr_d;

  always_comb begin
    psr_d = psr_q;
    if (en_i) begin
      psr_d = (psr_q & ~mask_i) | (raw_i & mask_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psr_q <= PSR_RESET;
    end else begin
      psr_q <= psr_d;
    end
  end

  assign psr_o = psr_q;

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute/writeback stage downstream of the 16-bit ALU.
//   clk     : clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ex_wb_if.slave
//             in_*  / flush        : ALU result slot, decoder flag controls, cancel
//             in_ready             : high only in RUN_ST
//             wb_en/wb_addr/wb_data: one-cycle register-file write port
//             psr / psr_c          : status word and carry fed back to the ALU
//             busy                 : high while a WAIT stall is counting
//             retire_count         : accepted, non-flushed instructions (wraps)
module ex_wb_stage
  import ex_pkg::*;
#(
  parameter int WIDTH      = EX_WIDTH,
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int WAIT_CNT_W = EX_WAIT_CNT_W,
  parameter int RETIRE_W   = EX_RETIRE_W
) (
  input  logic   clk,
  input  logic   reset_n,
  ex_wb_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] WaitOne   = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] WaitZero  = '0;
  localparam logic [RETIRE_W-1:0]   RetireOne = RETIRE_W'(1);

  ex_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic                  wbEn_q;
  logic [REG_ADDR_W-1:0] wbAddr_q;
  logic [WIDTH-1:0]      wbData_q;
  logic [RETIRE_W-1:0]   retire_q;

  logic                  inReady;
  logic                  accept;
  logic                  wbLoad;
  logic [WAIT_CNT_W-1:0] waitReq;
  logic [PSR_W-1:0]      flagMask;
  logic [PSR_W-1:0]      psrVal;

  assign inReady  = (state_q == RUN_ST);
  assign accept   = bus.in_valid & inReady & ~bus.flush;
  assign wbLoad   = accept & bus.in_y_valid & ~bus.in_wait;
  assign waitReq  = bus.in_y[WAIT_CNT_W-1:0];
  assign flagMask = bus.in_flags_en ? bus.in_flags_sel : '0;

  // WAIT sequencer: a non-zero count parks the stage for exactly that many
  // cycles; flush abandons the stall immediately.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    if (bus.flush) begin
      state_d   = RUN_ST;
      waitCnt_d = WaitZero;
    end else begin
      case (state_q)
        RUN_ST: begin
          if (accept && bus.in_wait && (waitReq != WaitZero)) begin
            state_d   = WAIT_ST;
            waitCnt_d = waitReq;
          end
        end
        WAIT_ST: begin
          if (waitCnt_q == WaitOne) begin
            state_d   = RUN_ST;
            waitCnt_d = WaitZero;
          end else begin
            waitCnt_d = waitCnt_q - WaitOne;
          end
        end
        default: begin
          state_d   = RUN_ST;
          waitCnt_d = WaitZero;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN_ST;
      waitCnt_q <= WaitZero;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Write port: address/data only move when a write actually happens, so a
  // flushed or non-writing instruction leaves the last write visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbEn_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
    end else begin
      wbEn_q <= wbLoad;
      if (wbLoad) begin
        wbAddr_q <= bus.in_rd;
        wbData_q <= bus.in_y;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_q <= '0;
    end else if (accept) begin
      retire_q <= retire_q + RetireOne;
    end
  end

  psr_reg u_psr (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .en_i    (accept),
    .mask_i  (flagMask),
    .raw_i   (bus.in_flags_raw),
    .psr_o   (psrVal)
  );

  assign bus.in_ready     = inReady;
  assign bus.wb_en        = wbEn_q;
  assign bus.wb_addr      = wbAddr_q;
  assign bus.wb_data      = wbData_q;
  assign bus.psr          = psrVal;
  assign bus.psr_c        = psrVal[PSR_C];
  assign bus.busy         = (state_q == WAIT_ST);
  assign bus.retire_count = retire_q;

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute/writeback pipeline stage directly downstream of the 16-bit ALU.
- Registers the ALU result into a register-file write port.
- Owns the processor status register (PSR {C,F,Z,L,N}) with per-bit update masking, and feeds PSR.C back to the ALU carry input.
- Implements the WAIT instruction as a counted stall and keeps a retired-instruction counter.

Parameters:
- WIDTH, 16, datapath width.
- REG_ADDR_W, 4, register-file address width.
- WAIT_CNT_W, 8, width of the WAIT stall counter; count taken from in_y[WAIT_CNT_W-1:0].
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU output slot holds an instruction.
- in_ready  out  1  stage accepts this cycle; transfer = in_valid & in_ready.
- in_y  in  WIDTH  ALU result.
- in_y_valid  in  1  result is to be written back (0 for CMP family and WAIT).
- in_rd  in  REG_ADDR_W  destination register.
- in_flags_raw  in  5  ALU raw flags {C,F,Z,L,N}.
- in_flags_sel  in  5  per-bit PSR update mask from the decoder.
- in_flags_en  in  1  global PSR update enable.
- in_wait  in  1  instruction is WAIT.
- flush  in  1  synchronous cancel; has priority over everything except reset.
- wb_en  out  1  register-file write strobe, one cycle.
- wb_addr  out  REG_ADDR_W  write address.
- wb_data  out  WIDTH  write data.
- psr  out  5  current PSR {C,F,Z,L,N}.
- psr_c  out  1  psr[4], drives the ALU carry input.
- busy  out  1  high while in WAIT_ST.
- retire_count  out  RETIRE_W  accepted, non-flushed instructions; wraps modulo 2^RETIRE_W.

Behaviour:
- States: RUN_ST, WAIT_ST.
- Reset (async, reset_n=0):
  - state=RUN_ST, wait counter=0.
  - wb_en=0, wb_addr=0, wb_data=0.
  - psr=5'b0, retire_count=0.
- in_ready = (state==RUN_ST). Combinational from state only; no dependency on in_valid.
- Accept = in_valid & in_ready & ~flush.
- Writeback, 1-cycle latency:
  - On every edge, wb_en <= accept & in_y_valid & ~in_wait.
  - When wb_en is set, wb_addr/wb_data load in_rd/in_y; otherwise they hold their previous values.
  - No register is special; r0 is writable.
- PSR update on accept:
  - mask = in_flags_en ? in_flags_sel : 0.
  - psr <= (psr & ~mask) | (in_flags_raw & mask).
  - Unselected bits hold.
  - The update is visible to the ALU in the next cycle, so back-to-back ADDC sees the new carry.
- WAIT:
  - On accept with in_wait and count N = in_y[WAIT_CNT_W-1:0]:
    - N=0: remain in RUN_ST; no stall.
    - N>0: counter<=N, go to WAIT_ST.
  - In WAIT_ST, counter decrements each cycle; exit to RUN_ST on the edge where counter==1. in_ready is therefore low for exactly N cycles.
  - WAIT updates the PSR per mask like any other instruction.
- retire_count increments by 1 on accept, including WAIT and CMP.
- flush:
  - Forces wb_en<=0.
  - Blocks PSR and retire_count updates for the instruction presented that cycle.
  - In WAIT_ST: state<=RUN_ST, counter<=0.
  - Already-registered wb_addr/wb_data hold.
- Reset mid-WAIT: immediate return to RUN_ST with all reset values.
- in_valid while in WAIT_ST is ignored; upstream must hold it.

Decomposition:
- Shared package ex_pkg holds:
  - PSR bit indices PSR_C=4, PSR_F=3, PSR_Z=2, PSR_L=1, PSR_N=0.
  - State encoding RUN_ST/WAIT_ST.
  - PSR reset value 5'b0.
- One natural sub-module, psr_reg: 5-bit masked-update register with async active-low reset and an enable input.
- Top level holds the FSM, wait counter, writeback register, retire counter.

Test Plan:
- Reset, then ADD result 16'h1234, in_rd=3, in_y_valid=1, flags_raw=5'b00100, sel=5'b01111, en=1 -> next cycle wb_en=1, wb_addr=3, wb_data=16'h1234, psr=5'b00100, retire_count=1.
- psr=5'b10001, then CMP with flags_raw=5'b01010, sel=5'b11111, en=1, in_y_valid=0 -> wb_en=0, psr=5'b01010; then en=0 with any flags_raw -> psr unchanged.
- Masking: psr=5'b11111, flags_raw=5'b00000, sel=5'b10000, en=1 -> psr=5'b01111 and psr_c=0 on the next cycle.
- WAIT with in_y=16'h0003 accepted at cycle t -> in_ready=0 and busy=1 in cycles t+1..t+3; in_ready=1 at t+4; wb_en stays 0. Repeat with in_y=0 -> in_ready never drops.
- WAIT of N=10, flush asserted at the 4th stall cycle -> next cycle in_ready=1, busy=0. Separately, flush with in_valid=1 -> no wb_en, psr and retire_count unchanged.
- Preload retire_count to 16'hFFFF via 65535 accepts, then one more -> retire_count=0. Assert reset_n=0 mid-WAIT -> all outputs at reset values immediately, without waiting for a clock edge.
